// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   uart_rx_state_e : receiver FSM states
//   UART_OVERSAMPLE : default rx_tick strobes per bit period
//   uart_parity_f   : XOR-reduce of up to 8 data bits (1 = odd number of ones)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int UART_OVERSAMPLE = 16;

  // Narrower words are zero-extended by the caller, which leaves the result unchanged.
  function automatic logic uart_parity_f(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk, rst : clock, async active-high reset (both flops load RST_VAL)
//   d        : asynchronous input
//   q        : synchronized output, 2 clk cycles behind d
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART serial receiver driven by an OVERSAMPLE x baud strobe.
// Finds the start bit, samples each bit at its centre and checks the stop bit.
// It also checks parity when the design is built with UART_RX_PARITY_EN.
// Each good word goes into a single-entry valid/ready holding register.
//   clk, rst   : clock, async active-high reset
//   rx_tick    : one-clk strobe at OVERSAMPLE x baud
//   rx_in      : asynchronous serial line, idles high
//   rx_data    : received word, valid while rx_valid is high
//   rx_valid   : holding register full
//   rx_ready   : host consumes the word on an edge where rx_valid && rx_ready
//   frame_err  : 1-clk pulse when the stop bit is sampled low
//   parity_err : 1-clk pulse on parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   overrun    : 1-clk pulse when a good word meets a full, unconsumed holding register
//   busy       : receiver is not idle
// Build option: define UART_RX_PARITY_EN to add the parity bit and the PARITY_ODD parameter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  ,parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int              CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   CNT_END = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]      IDX_END = 4'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_e       state;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

`ifndef UART_RX_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumption clears the holding register; a load on this same edge (in STOP) wins.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (rx_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              idx <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                // Glitch shorter than half a bit: drop it silently.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == CNT_END) begin
              cnt <= '0;
              sh  <= {rx_s, sh[DATA_BITS-1:1]};  // LSB arrives first, ends at bit 0
              idx <= idx + 4'd1;
`ifdef UART_RX_PARITY_EN
              if (idx == IDX_END) state <= PARITY;
`else
              if (idx == IDX_END) state <= STOP;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_END) begin
              cnt     <= '0;
              state   <= STOP;
              par_bad <= rx_s ^ uart_parity_f(8'(sh)) ^ PARITY_ODD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
          STOP: begin
            if (cnt == CNT_END) begin
              // Back to IDLE at mid stop bit so the next start edge can be caught early.
              cnt       <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
              frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              if (rx_s && !par_bad) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= sh;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Ticks from start-edge detection to the stop sample.
  localparam int FRAME_TICKS = OS / 2 + (DB + P + 1) * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_tick = 1'b0;
  logic          rx_in = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, overrun, busy;

  int vectors = 0;
  int miscompares = 0;
  int tick_no = 0;
  int div = 0;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tick    (rx_tick),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // rx_tick every 27 clks; tick_no counts the ticks the DUT has seen.
  always @(posedge clk) begin
    div     <= (div == 26) ? 0 : div + 1;
    rx_tick <= (div == 26);
    if (rx_tick) tick_no <= tick_no + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s wait expired at tick %0d", name, tick_no);
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    int          tick;
    logic [7:0]  data;
    bit          fe;
    bit          pe;
  } ev_t;
  ev_t        evq[$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  int         last_tick = 0;

  task automatic model_step();
    bit  fe = 0, pe = 0, ov = 0, load = 0, cons;
    ev_t ev;
    if (rst) begin
      exp_valid = 1'b0;
      evq.delete();
      last_tick = tick_no;
      chk("reset_outs", {rx_valid, frame_err, parity_err, overrun, busy, rx_data}, 32'h0);
      return;
    end
    cons = exp_valid && rx_ready;
    if (tick_no != last_tick) begin
      last_tick = tick_no;
      if (evq.size() > 0 && evq[0].tick == tick_no) begin
        ev = evq.pop_front();
        fe = ev.fe;
        pe = ev.pe;
        if (!fe && !pe) begin
          if (!exp_valid || rx_ready) begin
            load = 1;
            exp_data = ev.data;
          end else begin
            ov = 1;
          end
        end
      end
    end
    if (load) exp_valid = 1'b1;
    else if (cons) exp_valid = 1'b0;
    chk("model", {rx_valid, frame_err, parity_err, overrun, (exp_valid ? rx_data : 8'h00)},
                 {exp_valid, fe, pe, ov, (exp_valid ? exp_data : 8'h00)});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    model_step();
  end

  // ---------------- stimulus helpers (all return #1 after a clk edge) ----------------
  task automatic next_tick();
    int t = tick_no;
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tick_no == t && n < 100);
    if (tick_no == t) timeout("next_tick");
  endtask

  task automatic ticks(input int n);
    repeat (n) next_tick();
  endtask

  task automatic until_tick(input int id);
    int n = 0;
    while (tick_no < id && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tick_no < id) timeout("until_tick");
  endtask

  // Call aligned just after a tick edge; the start edge is seen on the following tick.
  task automatic send(input logic [7:0] d, input bit stop, input bit pbit);
    ev_t ev;
    ev.tick = tick_no + 1 + FRAME_TICKS;
    ev.data = d;
    ev.fe   = !stop;
    ev.pe   = (P == 1) && (pbit != ^d);
    evq.push_back(ev);
    rx_in = 1'b0;
    ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx_in = d[i];
      ticks(OS);
    end
    if (P == 1) begin
      rx_in = pbit;
      ticks(OS);
    end
    rx_in = stop;
    ticks(OS);
    rx_in = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int st, st2;
    logic [7:0] part;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rx_data, 0);
    @(negedge clk) rst = 1'b0;
    ticks(4);

    // 0x55, host ready: valid for one cycle, busy drops on the same edge
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        until_tick(st - 1);
        chk("f55_busy_pre", busy, 1);
        chk("f55_valid_pre", rx_valid, 0);
        until_tick(st);
        chk("f55_valid", rx_valid, 1);
        chk("f55_data", rx_data, 8'h55);
        chk("f55_busy_end", busy, 0);
        @(posedge clk);
        #1;
        chk("f55_valid_drop", rx_valid, 0);
      end
    join
    ticks(8);

    // false start: 4 ticks low
    next_tick();
    st = tick_no + 1 + OS / 2;
    rx_in = 1'b0;
    ticks(4);
    rx_in = 1'b1;
    until_tick(st - 1);
    chk("false_busy_pre", busy, 1);
    until_tick(st);
    chk("false_busy_end", busy, 0);
    chk("false_valid", rx_valid, 0);
    ticks(8);

    // 0xA3 with low stop bit, then 0x3C
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'hA3, 1'b0, 1'b0);
      begin
        until_tick(st);
        chk("fA3_frame_err", frame_err, 1);
        chk("fA3_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        chk("fA3_frame_err_drop", frame_err, 0);
      end
    join
    ticks(24);
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'h3C, 1'b1, 1'b0);
      begin
        until_tick(st);
        chk("f3C_valid", rx_valid, 1);
        chk("f3C_data", rx_data, 8'h3C);
        chk("f3C_frame_err", frame_err, 0);
      end
    join
    ticks(8);

    // back-to-back 0x12, 0x34 with host stalled: overrun, data held
    @(negedge clk) rx_ready = 1'b0;
    next_tick();
    st  = tick_no + 1 + FRAME_TICKS;
    st2 = tick_no + (DB + P + 2) * OS + 1 + FRAME_TICKS;
    fork
      begin
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b1, 1'b1);
      end
      begin
        until_tick(st);
        chk("f12_valid", rx_valid, 1);
        chk("f12_data", rx_data, 8'h12);
        until_tick(st2);
        chk("f34_overrun", overrun, 1);
        chk("f34_data_kept", rx_data, 8'h12);
        chk("f34_valid", rx_valid, 1);
        @(posedge clk);
        #1;
        chk("f34_overrun_drop", overrun, 0);
      end
    join
    ticks(8);

    // reset during data bit 3 with a word still held
    chk("hold_before_rst", rx_valid, 1);
    part = 8'hA5;
    next_tick();
    rx_in = 1'b0;
    ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx_in = part[i];
      ticks(OS);
    end
    rx_in = part[3];
    ticks(6);
    #4;
    rst = 1'b1;
    #1;
    chk("midrst_outs", {rx_valid, frame_err, parity_err, overrun, busy, rx_data}, 32'h0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_ready = 1'b1;
    ticks(4);
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'hC3, 1'b1, 1'b0);
      begin
        until_tick(st);
        chk("fC3_valid", rx_valid, 1);
        chk("fC3_data", rx_data, 8'hC3);
      end
    join
    ticks(8);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x0F needs parity bit 0
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'h0F, 1'b1, 1'b1);
      begin
        until_tick(st);
        chk("f0F_bad_parity_err", parity_err, 1);
        chk("f0F_bad_valid", rx_valid, 0);
      end
    join
    ticks(8);
    next_tick();
    st = tick_no + 1 + FRAME_TICKS;
    fork
      send(8'h0F, 1'b1, 1'b0);
      begin
        until_tick(st);
        chk("f0F_good_parity_err", parity_err, 0);
        chk("f0F_good_data", rx_data, 8'h0F);
      end
    join
    ticks(8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
